reg_bus_sched: RTL and testbench
================================

REG_BUS_SCHED -- requirements
Module: reg_bus_sched

Interface
REQ-001 Parameter: N_REG, default 4, number of 4-bit bus registers controlled (legal 2..4; index fields are 2 bits wide).
REQ-002 Parameter: SETUP_CYC, default 1, bus-drive cycles before capture (legal 1..3).
REQ-003 CP  input  1  clock; all state changes on rising edge.
REQ-004 MR  input  1  asynchronous, active-low master reset.
REQ-005 req  input  2  per-requester request; held high until ack.
REQ-006 op0, op1  input  2 each  command: 00 MOVE, 01 LOAD, 10 CLEAR, 11 reserved.
REQ-007 src0, src1  input  2 each  source register index (MOVE only).
REQ-008 dst0, dst1  input  2 each  destination register index (MOVE, LOAD).
REQ-009 ack  output  2  one-cycle completion pulse, one bit per requester.
REQ-010 err  output  1  high with ack when the command was rejected.
REQ-011 grant_id  output  1  requester currently served; valid while busy.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 oe_n  output  N_REG  active-low output enable per register (bus drive).
REQ-014 e_n  output  N_REG  active-low load enable per register.
REQ-015 ext_oe  output  1  active-high enable for the external data source onto the bus.
REQ-016 clr  output  1  active-high clear strobe for all registers.

Function
REQ-017 States: IDLE, SETUP, CAPTURE, ACK; the block serves one transaction at a time.
REQ-018 IDLE: when any req bit is high, latch the winner's op/src/dst and grant_id, then go to SETUP; with no request, stay in IDLE.
REQ-019 Arbitration is round-robin: if both req bits are high, grant the requester not granted last; a single requester is always granted.
REQ-020 The last-grant pointer updates only on entry to SETUP.
REQ-021 SETUP lasts exactly SETUP_CYC cycles: MOVE drives oe_n[src] low and LOAD drives ext_oe high; all e_n stay high.
REQ-022 CAPTURE lasts 1 cycle: bus drive from SETUP is held and e_n[dst] is low, so the destination captures on the rising edge ending CAPTURE.
REQ-023 CLEAR: the SETUP state drives nothing; CAPTURE asserts clr for 1 cycle; no oe_n/e_n is asserted.
REQ-024 Reserved op, or a src/dst index >= N_REG: go IDLE->ACK directly (1 cycle), assert err with ack, and drive no enable.
REQ-025 ACK lasts 1 cycle: ack[grant_id] high, all enables released, then return to IDLE.
REQ-026 Latency for a valid command: ack occurs SETUP_CYC+2 cycles after the IDLE cycle in which req was sampled.
REQ-027 A requester that keeps req high after ack starts a new transaction; it is arbitrated again in the next IDLE cycle.
REQ-028 Changes to op/src/dst while busy are ignored because commands are latched.
REQ-029 MOVE with src==dst is legal and follows the normal sequence.
REQ-030 At most one oe_n bit is low and at most one of {any oe_n low, ext_oe} is active in any cycle; no enable is active in IDLE or ACK.
REQ-031 All outputs are registered with no combinational path from req to the enables.

Reset
REQ-032 MR low: state=IDLE, oe_n and e_n all ones, ext_oe=0, clr=0, ack=0, err=0, busy=0, grant_id=0, last-grant pointer=1 (requester 0 wins first tie).
REQ-033 MR asserted mid-transaction aborts the transaction immediately with no ack; the requester must re-request after release.
REQ-034 The first rising CP edge after MR deasserts is treated as an IDLE cycle.

Verification
REQ-035 req0 MOVE src=2 dst=1, SETUP_CYC=1 -> cycle+1 oe_n=1011; cycle+2 oe_n=1011 and e_n=1101; cycle+3 ack=01, err=0.
REQ-036 req0 and req1 LOAD rise together after reset -> requester 0 is served first, then requester 1; held requests alternate 0,1,0,1.
REQ-037 req1 op=11 -> ack=10 with err=1 one cycle after sampling; oe_n and e_n stay 1111 and ext_oe stays 0.
REQ-038 CLEAR with SETUP_CYC=3 -> clr is high for exactly 1 cycle, 4 cycles after sampling, then ack.
REQ-039 MR pulsed low during CAPTURE -> all enables are released asynchronously, no ack is issued, and the block is IDLE afterwards.
REQ-040 Every cycle of a random bench, a checker confirms the bus exclusivity rule (REQ-030) and that busy is low exactly when the block is IDLE.

Source files
------------

// File: rtl/reg_bus_sched.sv
// Round-robin scheduler for two requesters driving a shared 4-bit register bus.
// Every output is registered. The output enables are decoded from the next state and the latched command.
module reg_bus_sched #(
  parameter int N_REG     = 4,
  parameter int SETUP_CYC = 1
) (
  input  logic             cp_i,
  input  logic             mr_ni,
  input  logic [1:0]       req_i,
  input  logic [1:0]       op0_i,
  input  logic [1:0]       op1_i,
  input  logic [1:0]       src0_i,
  input  logic [1:0]       src1_i,
  input  logic [1:0]       dst0_i,
  input  logic [1:0]       dst1_i,
  output logic [1:0]       ack_o,
  output logic             err_o,
  output logic             grant_id_o,
  output logic             busy_o,
  output logic [N_REG-1:0] oe_n_o,
  output logic [N_REG-1:0] e_n_o,
  output logic             ext_oe_o,
  output logic             clr_o
);

  localparam logic [1:0] OP_MOVE    = 2'd0;
  localparam logic [1:0] OP_LOAD    = 2'd1;
  localparam logic [1:0] OP_CLEAR   = 2'd2;
  localparam logic [1:0] SETUP_LAST = 2'(SETUP_CYC - 1);
  localparam logic [2:0] NREG_W     = 3'(N_REG);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_CAPTURE, S_ACK} state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d, src_q, src_d, dst_q, dst_d;
  logic       gid_q, gid_d, last_q, last_d, bad_q, bad_d;

  logic       win, win_bad;
  logic [1:0] win_op, win_src, win_dst;

  logic [1:0]       ack_q, ack_d;
  logic             err_q, err_d, busy_q, busy_d, ext_oe_q, ext_oe_d, clr_q, clr_d;
  logic [N_REG-1:0] oe_n_q, oe_n_d, e_n_q, e_n_d;
  logic             drive_move, drive_cap;

  // On a tie, the requester that was not granted last wins. A lone requester always wins.
  always_comb begin
    win     = (&req_i) ? ~last_q : req_i[1];
    win_op  = win ? op1_i  : op0_i;
    win_src = win ? src1_i : src0_i;
    win_dst = win ? dst1_i : dst0_i;
    win_bad = (win_op == 2'd3)
            || ((win_op == OP_MOVE) && ({1'b0, win_src} >= NREG_W))
            || (((win_op == OP_MOVE) || (win_op == OP_LOAD)) && ({1'b0, win_dst} >= NREG_W));
  end

  always_ff @(posedge cp_i or negedge mr_ni) begin
    if (!mr_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      gid_q   <= 1'b0;
      last_q  <= 1'b1;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      bad_q   <= bad_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    gid_d   = gid_q;
    last_d  = last_q;
    bad_d   = bad_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          gid_d = win;
          op_d  = win_op;
          src_d = win_src;
          dst_d = win_dst;
          bad_d = win_bad;
          cnt_d = '0;
          // A rejected command does not move the fairness pointer.
          if (win_bad) begin
            state_d = S_ACK;
          end else begin
            state_d = S_SETUP;
            last_d  = win;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) state_d = S_CAPTURE;
        else                     cnt_d   = cnt_q + 2'd1;
      end
      S_CAPTURE: state_d = S_ACK;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack_d      = '0;
    err_d      = 1'b0;
    ext_oe_d   = 1'b0;
    clr_d      = 1'b0;
    drive_move = 1'b0;
    drive_cap  = 1'b0;
    busy_d     = (state_d != S_IDLE);
    unique case (state_d)
      S_SETUP, S_CAPTURE: begin
        drive_move = (op_d == OP_MOVE);
        ext_oe_d   = (op_d == OP_LOAD);
        if (state_d == S_CAPTURE) begin
          drive_cap = (op_d == OP_MOVE) || (op_d == OP_LOAD);
          clr_d     = (op_d == OP_CLEAR);
        end
      end
      S_ACK: begin
        ack_d = gid_d ? 2'b10 : 2'b01;
        err_d = bad_d;
      end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < N_REG; gi++) begin : g_en
    assign oe_n_d[gi] = ~(drive_move && (src_d == 2'(gi)));
    assign e_n_d[gi]  = ~(drive_cap  && (dst_d == 2'(gi)));
  end

  always_ff @(posedge cp_i or negedge mr_ni) begin
    if (!mr_ni) begin
      ack_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      ext_oe_q <= 1'b0;
      clr_q    <= 1'b0;
      oe_n_q   <= '1;
      e_n_q    <= '1;
    end else begin
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      ext_oe_q <= ext_oe_d;
      clr_q    <= clr_d;
      oe_n_q   <= oe_n_d;
      e_n_q    <= e_n_d;
    end
  end

  assign ack_o      = ack_q;
  assign err_o      = err_q;
  assign busy_o     = busy_q;
  assign grant_id_o = gid_q;
  assign ext_oe_o   = ext_oe_q;
  assign clr_o      = clr_q;
  assign oe_n_o     = oe_n_q;
  assign e_n_o      = e_n_q;

endmodule

// File: tb/tb_reg_bus_sched.sv
// Bench for reg_bus_sched: two configurations share one stimulus stream and are checked against a transaction-level model.
// Instance A uses N_REG=4 and SETUP_CYC=1. Instance B uses N_REG=3 and SETUP_CYC=3.
module tb_reg_bus_sched;
  localparam int NA = 4, SA = 1, NB = 3, SB = 3;

  logic clk = 1'b0, mr_n = 1'b0;
  logic [1:0] req = '0, op0 = '0, op1 = '0, src0 = '0, src1 = '0, dst0 = '0, dst1 = '0;
  logic [1:0] a_ack, b_ack;
  logic a_err, b_err, a_gid, b_gid, a_busy, b_busy, a_ext, b_ext, a_clr, b_clr;
  logic [3:0] a_oe, a_en;
  logic [2:0] b_oe, b_en;

  always #5 clk = ~clk;

  reg_bus_sched #(.N_REG(NA), .SETUP_CYC(SA)) u_a (
    .cp_i(clk), .mr_ni(mr_n), .req_i(req), .op0_i(op0), .op1_i(op1),
    .src0_i(src0), .src1_i(src1), .dst0_i(dst0), .dst1_i(dst1),
    .ack_o(a_ack), .err_o(a_err), .grant_id_o(a_gid), .busy_o(a_busy),
    .oe_n_o(a_oe), .e_n_o(a_en), .ext_oe_o(a_ext), .clr_o(a_clr));

  reg_bus_sched #(.N_REG(NB), .SETUP_CYC(SB)) u_b (
    .cp_i(clk), .mr_ni(mr_n), .req_i(req), .op0_i(op0), .op1_i(op1),
    .src0_i(src0), .src1_i(src1), .dst0_i(dst0), .dst1_i(dst1),
    .ack_o(b_ack), .err_o(b_err), .grant_id_o(b_gid), .busy_o(b_busy),
    .oe_n_o(b_oe), .e_n_o(b_en), .ext_oe_o(b_ext), .clr_o(b_clr));

  int n_cmp = 0, n_fail = 0;

  // Model state per instance. m_k counts cycles since the sampling edge; 0 means idle.
  int m_k[2], m_len[2];
  logic m_gid[2], m_last[2], m_bad[2];
  logic [1:0] m_op[2], m_src[2], m_dst[2];

  function automatic int setup_of(int i); return (i == 0) ? SA : SB; endfunction
  function automatic int nreg_of(int i);  return (i == 0) ? NA : NB; endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_k[i] = 0; m_len[i] = 1; m_last[i] = 1'b1; m_gid[i] = 1'b0; m_bad[i] = 1'b0;
      m_op[i] = '0; m_src[i] = '0; m_dst[i] = '0;
    end
  endtask

  task automatic model_edge();
    logic w;
    logic [1:0] op, src, dst;
    bit bad;
    for (int i = 0; i < 2; i++) begin
      if (m_k[i] == 0) begin
        if (req != 2'b00) begin
          w   = (req == 2'b11) ? !m_last[i] : req[1];
          op  = w ? op1 : op0;
          src = w ? src1 : src0;
          dst = w ? dst1 : dst0;
          bad = (op == 2'd3) || (op == 2'd0 && (int'(src) >= nreg_of(i) || int'(dst) >= nreg_of(i)))
                || (op == 2'd1 && int'(dst) >= nreg_of(i));
          m_gid[i] = w; m_op[i] = op; m_src[i] = src; m_dst[i] = dst; m_bad[i] = bad;
          m_len[i] = bad ? 1 : setup_of(i) + 2;
          m_k[i] = 1;
          if (!bad) m_last[i] = w;
        end
      end else if (m_k[i] == m_len[i]) m_k[i] = 0;
      else m_k[i]++;
    end
  endtask

  // Vector layout: {ack, err, gid (only while busy), busy, oe_n[3:0], e_n[3:0], ext_oe, clr}.
  function automatic logic [14:0] exp_vec(int i);
    logic [3:0] oe, en;
    logic [1:0] ack;
    logic er, gid, bsy, ext, cl, cap;
    oe = 4'hF; en = 4'hF; ack = '0; er = 0; gid = 0; ext = 0; cl = 0;
    bsy = (m_k[i] != 0);
    if (bsy) begin
      gid = m_gid[i];
      if (m_k[i] == m_len[i]) begin
        ack = m_gid[i] ? 2'b10 : 2'b01;
        er  = m_bad[i];
      end else begin
        cap = (m_k[i] == m_len[i] - 1);
        case (m_op[i])
          2'd0: begin oe[m_src[i]] = 1'b0; if (cap) en[m_dst[i]] = 1'b0; end
          2'd1: begin ext = 1'b1; if (cap) en[m_dst[i]] = 1'b0; end
          default: if (cap) cl = 1'b1;
        endcase
      end
    end
    return {ack, er, gid, bsy, oe, en, ext, cl};
  endfunction

  function automatic logic [14:0] act_vec(int i);
    if (i == 0) return {a_ack, a_err, a_busy & a_gid, a_busy, a_oe, a_en, a_ext, a_clr};
    return {b_ack, b_err, b_busy & b_gid, b_busy, 1'b1, b_oe, 1'b1, b_en, b_ext, b_clr};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic settle();
    req = 2'b00;
    for (int c = 0; c < 8; c++) tick();
  endtask

  task automatic do_reset();
    mr_n = 1'b0;
    req = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    mr_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    mr_n = 1'b0;
    req = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({a_ack, a_err, a_gid, a_busy, a_oe, a_en, a_ext, a_clr} !== {2'b00, 3'b000, 4'hF, 4'hF, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_a got=%b %b %b %b %b %b %b %b", a_ack, a_err, a_gid, a_busy, a_oe, a_en, a_ext, a_clr);
    end
    n_cmp++;
    if ({b_ack, b_err, b_gid, b_busy, b_oe, b_en, b_ext, b_clr} !== {2'b00, 3'b000, 3'b111, 3'b111, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_b got=%b %b %b %b %b %b %b %b", b_ack, b_err, b_gid, b_busy, b_oe, b_en, b_ext, b_clr);
    end
    req = 2'b00;
    mr_n = 1'b1;
    model_reset();
  endtask

  task automatic test_move();
    req = 2'b01; op0 = 2'd0; src0 = 2'd2; dst0 = 2'd1;
    tick();
    n_cmp++;
    if ({a_oe, a_en, a_busy} !== {4'b1011, 4'b1111, 1'b1}) begin
      n_fail++; $display("FAIL move_setup got oe=%b e=%b busy=%b want 1011 1111 1", a_oe, a_en, a_busy);
    end
    op0 = 2'd2; src0 = 2'd0;
    tick();
    n_cmp++;
    if ({a_oe, a_en} !== {4'b1011, 4'b1101}) begin
      n_fail++; $display("FAIL move_capture got oe=%b e=%b want 1011 1101", a_oe, a_en);
    end
    tick();
    n_cmp++;
    if ({a_ack, a_err, a_oe, a_en} !== {2'b01, 1'b0, 4'hF, 4'hF}) begin
      n_fail++; $display("FAIL move_ack got ack=%b err=%b oe=%b e=%b want 01 0 1111 1111", a_ack, a_err, a_oe, a_en);
    end
    settle();
  endtask

  task automatic test_round_robin();
    logic exp_id;
    int got;
    do_reset();
    req = 2'b11; op0 = 2'd1; op1 = 2'd1; dst0 = 2'd1; dst1 = 2'd2;
    exp_id = 1'b0; got = 0;
    for (int c = 0; c < 60 && got < 4; c++) begin
      tick();
      if (a_ack != 2'b00) begin
        n_cmp++;
        if (a_ack !== (exp_id ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL round_robin ack#%0d got=%b want=%b", got, a_ack, exp_id ? 2'b10 : 2'b01);
        end
        exp_id = !exp_id;
        got++;
      end
    end
    n_cmp++;
    if (got != 4) begin
      n_fail++; $display("FAIL round_robin_count got=%0d acks want 4", got);
    end
    settle();
  endtask

  task automatic test_reserved();
    req = 2'b10; op1 = 2'd3;
    tick();
    n_cmp++;
    if ({a_ack, a_err, a_oe, a_en, a_ext} !== {2'b10, 1'b1, 4'hF, 4'hF, 1'b0}) begin
      n_fail++; $display("FAIL reserved_a got ack=%b err=%b oe=%b e=%b ext=%b", a_ack, a_err, a_oe, a_en, a_ext);
    end
    n_cmp++;
    if ({b_ack, b_err, b_oe, b_en, b_ext} !== {2'b10, 1'b1, 3'b111, 3'b111, 1'b0}) begin
      n_fail++; $display("FAIL reserved_b got ack=%b err=%b oe=%b e=%b ext=%b", b_ack, b_err, b_oe, b_en, b_ext);
    end
    req = 2'b00;
    tick();
    n_cmp++;
    if ({a_ack, a_busy} !== 3'b000) begin
      n_fail++; $display("FAIL reserved_after got ack=%b busy=%b want 00 0", a_ack, a_busy);
    end
    settle();
  endtask

  task automatic test_clear();
    int clr_cnt, clr_at, ack_at;
    logic [1:0] ack_val;
    req = 2'b01; op0 = 2'd2;
    clr_cnt = 0; clr_at = -1; ack_at = -1; ack_val = '0;
    for (int t = 1; t <= 8 && ack_at < 0; t++) begin
      tick();
      if (b_clr) begin clr_cnt++; clr_at = t; end
      if (b_ack != 2'b00) begin ack_at = t; ack_val = b_ack; req = 2'b00; end
    end
    n_cmp++;
    if (clr_cnt != 1 || clr_at != 4) begin
      n_fail++; $display("FAIL clear_strobe got count=%0d at=%0d want 1 at 4", clr_cnt, clr_at);
    end
    n_cmp++;
    if (ack_at != 5 || ack_val !== 2'b01) begin
      n_fail++; $display("FAIL clear_ack got at=%0d ack=%b want 5 01", ack_at, ack_val);
    end
    settle();
  endtask

  task automatic test_bad_index();
    req = 2'b01; op0 = 2'd0; src0 = 2'd3; dst0 = 2'd0;
    tick();
    n_cmp++;
    if ({b_ack, b_err, b_oe, b_en} !== {2'b01, 1'b1, 3'b111, 3'b111}) begin
      n_fail++; $display("FAIL bad_index_b got ack=%b err=%b oe=%b e=%b want 01 1 111 111", b_ack, b_err, b_oe, b_en);
    end
    n_cmp++;
    if ({a_ack, a_busy, a_oe} !== {2'b00, 1'b1, 4'b0111}) begin
      n_fail++; $display("FAIL bad_index_a got ack=%b busy=%b oe=%b want 00 1 0111", a_ack, a_busy, a_oe);
    end
    settle();
  endtask

  task automatic test_mr_abort();
    int acks;
    req = 2'b01; op0 = 2'd0; src0 = 2'd0; dst0 = 2'd3;
    tick();
    tick();
    n_cmp++;
    if ({a_oe, a_en} !== {4'b1110, 4'b0111}) begin
      n_fail++; $display("FAIL abort_capture got oe=%b e=%b want 1110 0111", a_oe, a_en);
    end
    req = 2'b00;
    #1 mr_n = 1'b0;
    #1;
    n_cmp++;
    if ({a_oe, a_en, a_ext, a_clr, a_busy, a_ack, b_oe, b_en, b_busy} !== {4'hF, 4'hF, 3'b000, 2'b00, 3'b111, 3'b111, 1'b0}) begin
      n_fail++; $display("FAIL abort_release got a oe=%b e=%b busy=%b b oe=%b e=%b busy=%b", a_oe, a_en, a_busy, b_oe, b_en, b_busy);
    end
    #2 mr_n = 1'b1;
    model_reset();
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (a_ack != 2'b00 || b_ack != 2'b00 || a_busy || b_busy) acks++;
    end
    n_cmp++;
    if (acks != 0) begin
      n_fail++; $display("FAIL abort_idle got %0d non-idle cycles want 0", acks);
    end
  endtask

  task automatic test_random();
    logic [14:0] e, a;
    logic [3:0] oe, en;
    logic ext, cl, bsy;
    logic [1:0] ack;
    int lows;
    bit ok;
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        e = exp_vec(i);
        a = act_vec(i);
        n_cmp++;
        if (a !== e) begin
          n_fail++; $display("FAIL random_outputs inst=%0d cyc=%0d got=%b want=%b", i, c, a, e);
        end
        {ack, oe, en, ext, cl, bsy} = {a[14:13], a[9:6], a[5:2], a[1], a[0], a[10]};
        lows = $countones(~oe);
        ok = (lows <= 1) && !(lows > 0 && ext);
        if (!bsy || ack != 2'b00) ok = ok && (lows == 0) && (en == 4'hF) && !ext && !cl;
        n_cmp++;
        if (!ok) begin
          n_fail++; $display("FAIL random_exclusive inst=%0d cyc=%0d oe=%b e=%b ext=%b busy=%b ack=%b", i, c, oe, en, ext, bsy, ack);
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (req[r] && a_ack[r]) req[r] = 1'($urandom_range(0, 1));
        else if (!req[r])       req[r] = ($urandom_range(0, 3) == 0);
      end
      op0 = 2'($urandom_range(0, 3));  op1 = 2'($urandom_range(0, 3));
      src0 = 2'($urandom_range(0, 3)); src1 = 2'($urandom_range(0, 3));
      dst0 = 2'($urandom_range(0, 3)); dst1 = 2'($urandom_range(0, 3));
    end
    settle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_move();
    test_round_robin();
    test_reserved();
    test_clear();
    test_bad_index();
    test_mr_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
